// File: rtl/scene_renderer_pkg.sv
// Shared widths, colour constants and the scene parameter record for the Flappy Bird scene renderer.
package scene_renderer_pkg;

  localparam int unsigned POS_X_W  = 10;
  localparam int unsigned POS_Y_W  = 9;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [POS_X_W-1:0] pos_x_t;
  typedef logic [POS_Y_W-1:0] pos_y_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Colours are bbbb_gggg_rrrr
  localparam color_t COL_BIRD     = 12'h0FF;
  localparam color_t COL_PIPE     = 12'h2C3;
  localparam color_t COL_GROUND_A = 12'h07B;
  localparam color_t COL_GROUND_B = 12'h05A;
  localparam color_t COL_SKY      = 12'hEC7;

  typedef struct packed {
    pos_y_t bird_y;
    pos_x_t pipe_x;
    pos_y_t gap_y;
  } scene_t;

  localparam int unsigned SCENE_W = $bits(scene_t);

  // Pipe parked at the right screen edge keeps it off-screen until game logic places it
  localparam scene_t SCENE_RESET = '{bird_y: 9'd234, pipe_x: 10'(SCREEN_W), gap_y: 9'd190};

endpackage

// File: rtl/scene_param_buffer.sv
// Pending/active register pair with valid/ready intake; pending data moves to active on swap.
module scene_param_buffer #(
  parameter int unsigned       DATA_W       = 28,
  parameter logic [DATA_W-1:0] RESET_ACTIVE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] active_data
);

  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              accept;

  // Swap reads the old pending value, so pending may be refilled on the swap cycle itself
  assign in_ready    = !pend_valid_q || swap;
  assign accept      = in_valid && in_ready;
  assign active_data = active_q;

  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    if (swap && pend_valid_q) begin
      active_d = pend_q;
    end
    if (accept) begin
      pend_d       = in_data;
      pend_valid_d = 1'b1;
    end else if (swap) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= RESET_ACTIVE;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
    end
  end

endmodule

// File: rtl/scene_renderer.sv
// Zero-latency pixel colour source for the Flappy Bird scene, with frame tick, frame counter
// and per-frame bird/pipe collision flag; scene updates are latched only at frame boundaries.
module scene_renderer
  import scene_renderer_pkg::*;
#(
  parameter int unsigned BIRD_X   = 100,
  parameter int unsigned PIPE_W   = 52,
  parameter int unsigned GAP_H    = 100,
  parameter int unsigned GROUND_Y = 432
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [POS_X_W-1:0]   curr_x,
  input  logic [POS_Y_W-1:0]   curr_y,
  input  logic                 vs,
  input  logic                 run,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [POS_Y_W-1:0]   upd_bird_y,
  input  logic [POS_X_W-1:0]   upd_pipe_x,
  input  logic [POS_Y_W-1:0]   upd_gap_y,
  output logic [COLOR_W-1:0]   color,
  output logic                 frame_tick,
  output logic [15:0]          frame_cnt,
  output logic                 hit
);

  logic        vs_q, vs_d;
  logic        frame_tick_q, frame_tick_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  scroll_q, scroll_d;
  logic        hit_acc_q, hit_acc_d;
  logic        hit_q, hit_d;

  logic   tick_edge;
  scene_t upd_scene, scene;

  assign tick_edge = vs && !vs_q;
  assign upd_scene = '{bird_y: upd_bird_y, pipe_x: upd_pipe_x, gap_y: upd_gap_y};

  scene_param_buffer #(
    .DATA_W      (SCENE_W),
    .RESET_ACTIVE(SCENE_RESET)
  ) u_param_buf (
    .clk        (clk),
    .rst        (rst),
    .swap       (tick_edge),
    .in_valid   (upd_valid),
    .in_ready   (upd_ready),
    .in_data    (upd_scene),
    .active_data(scene)
  );

  logic [9:0]  y10, bird_top, bird_bot, gap_top, gap_bot;
  logic [10:0] x11, pipe_l, pipe_r;
  logic [9:0]  stripe_sum;
  logic        in_bird, in_pipe, in_ground;

  always_comb begin
    y10        = {1'b0, curr_y};
    bird_top   = {1'b0, scene.bird_y};
    bird_bot   = bird_top + 10'd12;
    gap_top    = {1'b0, scene.gap_y};
    gap_bot    = gap_top + 10'(GAP_H);
    x11        = {1'b0, curr_x};
    pipe_l     = {1'b0, scene.pipe_x};
    pipe_r     = pipe_l + 11'(PIPE_W - 1);
    stripe_sum = curr_x + {6'b0, scroll_q};

    in_bird   = (curr_x >= 10'(BIRD_X)) && (curr_x < 10'(BIRD_X + 16))
             && (y10 >= bird_top) && (y10 < bird_bot);
    in_pipe   = (x11 >= pipe_l) && (x11 <= pipe_r)
             && !((y10 >= gap_top) && (y10 < gap_bot));
    in_ground = (curr_y >= 9'(GROUND_Y));

    if (in_bird) begin
      color = COL_BIRD;
    end else if (in_pipe) begin
      color = COL_PIPE;
    end else if (in_ground) begin
      color = stripe_sum[3] ? COL_GROUND_B : COL_GROUND_A;
    end else begin
      color = COL_SKY;
    end
  end

  always_comb begin
    vs_d         = vs;
    frame_tick_d = tick_edge;
    frame_cnt_d  = frame_cnt_q;
    scroll_d     = scroll_q;
    hit_d        = hit_q;
    hit_acc_d    = hit_acc_q || (in_bird && in_pipe);
    // Overlap seen on the tick cycle seeds the new frame's accumulator
    if (tick_edge) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      hit_d       = hit_acc_q;
      hit_acc_d   = in_bird && in_pipe;
      if (run) begin
        scroll_d = scroll_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      scroll_q     <= '0;
      hit_acc_q    <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      vs_q         <= vs_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      scroll_q     <= scroll_d;
      hit_acc_q    <= hit_acc_d;
      hit_q        <= hit_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Directed bench for scene_renderer: reset state, scene swap timing, handshake stall,
// ground scroll, colour priority/boundaries, collision flag and mid-frame reset.
module tb_scene_renderer;

  logic        clk;
  logic        rst;
  logic [9:0]  curr_x;
  logic [8:0]  curr_y;
  logic        vs;
  logic        run;
  logic        upd_valid;
  logic        upd_ready;
  logic [8:0]  upd_bird_y;
  logic [9:0]  upd_pipe_x;
  logic [8:0]  upd_gap_y;
  logic [11:0] color;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        hit;

  int unsigned checks = 0;
  int unsigned errors = 0;

  scene_renderer #(
    .BIRD_X  (100),
    .PIPE_W  (52),
    .GAP_H   (100),
    .GROUND_Y(432)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .curr_x    (curr_x),
    .curr_y    (curr_y),
    .vs        (vs),
    .run       (run),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_bird_y(upd_bird_y),
    .upd_pipe_x(upd_pipe_x),
    .upd_gap_y (upd_gap_y),
    .color     (color),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt),
    .hit       (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    curr_x = 10'(x);
    curr_y = 9'(y);
    #1;
    check(tag, {4'h0, color}, {4'h0, exp});
  endtask

  task automatic send(input int b, input int p, input int g);
    upd_valid  = 1'b1;
    upd_bird_y = 9'(b);
    upd_pipe_x = 10'(p);
    upd_gap_y  = 9'(g);
    @(posedge clk); #1;
    upd_valid  = 1'b0;
  endtask

  task automatic tick_rise();
    curr_x = '0;
    curr_y = '0;
    vs = 1'b1;
    @(posedge clk); #1;
    check("frame_tick_pulse", {15'd0, frame_tick}, 16'd1);
  endtask

  task automatic tick_fall();
    @(posedge clk); #1;
    check("frame_tick_single", {15'd0, frame_tick}, 16'd0);
    vs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_tick();
    tick_rise();
    tick_fall();
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; run = 1'b0; upd_valid = 1'b0;
    upd_bird_y = '0; upd_pipe_x = '0; upd_gap_y = '0;
    curr_x = 10'd10; curr_y = 9'd10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    pix("reset_sky", 10, 10, 12'hEC7);
    check("reset_ready", {15'd0, upd_ready}, 16'd1);
    check("reset_hit", {15'd0, hit}, 16'd0);
    check("reset_frame_cnt", frame_cnt, 16'd0);
    check("reset_tick", {15'd0, frame_tick}, 16'd0);
    pix("reset_pipe_hidden", 10, 240, 12'hEC7);
    pix("reset_bird", 105, 240, 12'h0FF);
    pix("reset_ground", 6, 440, 12'h07B);

    // First update waits for the frame boundary
    send(200, 90, 150);
    check("pend_not_ready", {15'd0, upd_ready}, 16'd0);
    pix("pre_tick_old_bird", 105, 240, 12'h0FF);
    pix("pre_tick_new_bird_absent", 105, 205, 12'hEC7);
    do_tick();
    check("frame_cnt_1", frame_cnt, 16'd1);
    check("ready_after_swap", {15'd0, upd_ready}, 16'd1);
    pix("new_bird", 105, 205, 12'h0FF);
    pix("pipe_body", 95, 100, 12'h2C3);
    pix("pipe_gap", 95, 160, 12'hEC7);

    // A accepted, B stalled until the tick, A shown first then B
    upd_valid = 1'b1; upd_bird_y = 9'd50; upd_pipe_x = 10'd300; upd_gap_y = 9'd100;
    #1 check("A_ready", {15'd0, upd_ready}, 16'd1);
    @(posedge clk); #1;
    upd_bird_y = 9'd60; upd_pipe_x = 10'd400; upd_gap_y = 9'd120;
    check("B_stalled", {15'd0, upd_ready}, 16'd0);
    @(posedge clk); #1;
    check("B_still_stalled", {15'd0, upd_ready}, 16'd0);
    vs = 1'b1; #1;
    check("B_ready_on_tick", {15'd0, upd_ready}, 16'd1);
    tick_rise();
    upd_valid = 1'b0;
    tick_fall();
    check("B_pending", {15'd0, upd_ready}, 16'd0);
    pix("A_bird", 105, 55, 12'h0FF);
    pix("A_not_B_bird", 105, 65, 12'hEC7);
    pix("A_pipe", 310, 50, 12'h2C3);
    do_tick();
    check("B_drained", {15'd0, upd_ready}, 16'd1);
    pix("B_bird", 105, 65, 12'h0FF);
    pix("B_pipe", 410, 50, 12'h2C3);
    pix("A_pipe_gone", 310, 50, 12'hEC7);
    check("frame_cnt_3", frame_cnt, 16'd3);

    // Scroll: 9 running frames
    run = 1'b1;
    repeat (9) do_tick();
    check("frame_cnt_12", frame_cnt, 16'd12);
    pix("stripe_x0", 0, 440, 12'h05A);
    pix("stripe_x7", 7, 440, 12'h07B);
    pix("sky_above_ground", 0, 431, 12'hEC7);
    pix("pipe_over_ground", 410, 440, 12'h2C3);
    run = 1'b0;
    do_tick();
    pix("scroll_hold", 6, 440, 12'h05A);

    // Collision frame
    send(100, 100, 300);
    do_tick();
    pix("bird_over_pipe", 105, 105, 12'h0FF);
    repeat (3) @(posedge clk);
    #1 check("hit_waits_tick", {15'd0, hit}, 16'd0);
    pix("pipe_right_edge", 151, 50, 12'h2C3);
    pix("pipe_past_right", 152, 50, 12'hEC7);
    send(100, 100, 95);
    do_tick();
    check("hit_set", {15'd0, hit}, 16'd1);
    pix("gap_top_row", 151, 95, 12'hEC7);
    pix("gap_bottom_edge", 151, 195, 12'h2C3);
    pix("bird_corner", 115, 111, 12'h0FF);
    pix("bird_right_past", 116, 111, 12'hEC7);
    pix("bird_below_past", 115, 112, 12'hEC7);
    pix("bird_in_gap", 105, 105, 12'h0FF);
    repeat (3) @(posedge clk);
    #1 check("hit_held_midframe", {15'd0, hit}, 16'd1);
    do_tick();
    check("hit_clear", {15'd0, hit}, 16'd0);

    // Mid-frame reset drops the pending update
    send(300, 200, 50);
    check("pend_before_rst", {15'd0, upd_ready}, 16'd0);
    rst = 1'b1;
    #1;
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_ready", {15'd0, upd_ready}, 16'd1);
    check("rst_hit", {15'd0, hit}, 16'd0);
    pix("rst_scene_bird", 105, 240, 12'h0FF);
    pix("rst_scene_pipe", 105, 105, 12'hEC7);
    pix("rst_scroll", 6, 440, 12'h07B);
    @(posedge clk); #1;
    rst = 1'b0;
    do_tick();
    check("post_rst_frame_cnt", frame_cnt, 16'd1);
    pix("dropped_bird", 105, 305, 12'hEC7);
    pix("dropped_pipe", 210, 100, 12'hEC7);
    pix("reset_bird_kept", 105, 240, 12'h0FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
